pipelined_barrel_rotator: RTL and testbench
===========================================

Name: pipelined_barrel_rotator

Overview:
- Variable-amount, bidirectional circular rotator, pipelined as a log2(N)-stage barrel.
- Sits downstream of the operand/amount issue logic in the arithmetic pipeline.
- Generalises the fixed-S circular shifts to a runtime amount and direction.
- Valid/ready handshake on both sides; full throughput of one word per cycle with backpressure propagation.

Parameters:
- N, 8, data width in bits; must be a power of 2 and at least 2.
- SW, $clog2(N), shift-amount width; also the number of pipeline stages.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- up_valid  in  1  upstream word present.
- up_ready  out  1  this block accepts upstream word this cycle.
- up_data  in  N  word to rotate.
- up_amt  in  SW  rotate amount, 0..N-1.
- up_dir  in  1  0 = rotate left, 1 = rotate right.
- down_valid  out  1  rotated word available.
- down_ready  in  1  downstream accepts word.
- down_data  out  N  rotated result.

Behaviour:
- Reset: while rst_n=0, all stage valid bits=0 and all stage data/amt/dir registers=0 (asynchronous assertion, synchronous-release use). Therefore down_valid=0 and down_data=0. up_ready is combinational and equals 1 once the pipeline is empty.
- Stages: k = 0..SW-1.
  - Stage k registers data_k, amt_k, dir_k, v_k.
  - Stage k rotates its input by 2^k positions in direction dir when amt bit k=1; otherwise it passes the word unchanged.
  - Stage 0 input is up_*; stage k input is stage k-1 output.
- Result: rotation by up_amt, taken modulo N implicitly. up_amt=0 yields the input unchanged in either direction.
- Enables:
  - en_SW = down_ready.
  - en_k = !v_k || en_(k+1).
  - up_ready = en_0.
  - When en_k=1, stage k loads its input and v_k <= v_(k-1), with v_(-1) = up_valid.
  - When en_k=0, stage k holds all its registers.
- Transfer: an upstream transfer occurs when up_valid && up_ready; a downstream transfer occurs when down_valid && down_ready.
- Outputs: down_valid = v_(SW-1); down_data = data_(SW-1).
- Latency: SW cycles from accepted input to down_valid (3 for N=8) when there is no backpressure. Throughput is 1 word/cycle.
- Backpressure:
  - If down_ready=0, down_valid and down_data hold stable until taken.
  - Bubbles inside the pipeline are squeezed out, so a full pipeline deasserts up_ready only when every stage is valid.
- Simultaneous accept and emit on a full pipeline with down_ready=1: the pipeline advances and up_ready=1. No loss and no duplication.
- Ordering: output order equals input order.
- Upstream contract: up_data, up_amt and up_dir must be stable while up_valid=1 and up_ready=0.
- Reset mid-operation: all in-flight words are discarded and down_valid drops asynchronously to 0.

Optional Feature:
- Macro: BARREL_ROTATOR_IN_REG_EN.
- Defined:
  - Adds an input stage that registers up_data, up_amt, up_dir and up_valid ahead of stage 0, using the same enable rule.
  - Latency becomes SW+1 (4 for N=8).
  - up_ready depends only on that input stage and downstream enables.
- Undefined: latency is SW and stage 0 is fed directly from the up_* ports.
- Functional results, ordering and backpressure rules are identical in both builds.

Test Plan:
1. Reset, then up_valid=1, data=8'b10110101, amt=3, dir=0, down_ready=1. Expect down_data=8'b10101101 with down_valid=1 exactly 3 cycles later (4 with the macro defined).
2. Same data, amt=3, dir=1 -> 8'b10110110. Then data=8'b01100110 with amt=3, dir=1 -> 8'b11001100, and with dir=0 -> 8'b00110011.
3. Stream 8 back-to-back words with amt=0..7, dir=0, data=8'b00000001. Expect outputs 1<<amt on consecutive cycles, in order, with up_ready=1 throughout.
4. Hold down_ready=0 while feeding 5 words.
   - Expect up_ready=0 after 3 accepted words (4 with the macro).
   - Expect down_data stable.
   - Release down_ready: all 5 words emerge in order with correct values.
5. Pulse rst_n=0 mid-stream with 2 words in flight. Expect down_valid=0 immediately and no stale word after release.
6. Random data/amt/dir with random down_ready, checked against a reference model ((x<<s)|(x>>(N-s)) for left, mirror for right). Expect no mismatches, drops or duplicates.

Source files
------------

// File: rtl/pipelined_barrel_rotator.sv
// Pipelined variable-amount circular rotator: one barrel stage per amount bit, valid/ready flow.
// Define BARREL_ROTATOR_IN_REG_EN to add a plain register stage ahead of the barrel.
module pipelined_barrel_rotator #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  input  logic          up_dir,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

`ifdef BARREL_ROTATOR_IN_REG_EN
  localparam int unsigned InReg = 1;
`else
  localparam int unsigned InReg = 0;
`endif
  localparam int unsigned NS = SW + InReg;

  logic [NS-1:0]         v_q, v_d;
  logic [NS-1:0]         dir_q, dir_d;
  logic [NS-1:0][N-1:0]  data_q, data_d;
  logic [NS-1:0][SW-1:0] amt_q, amt_d;
  logic [NS:0]           en;

  // Rotate through a doubled word so the wrapped bits fall out of a plain shift.
  function automatic logic [N-1:0] rot_pow2(input logic [N-1:0] x, input logic dir,
                                            input int unsigned sh);
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    dbl = {x, x};
    if (dir) begin
      shifted = dbl >> sh;
      return shifted[N-1:0];
    end else begin
      shifted = dbl << sh;
      return shifted[2*N-1:N];
    end
  endfunction

  assign en[NS] = down_ready;

  for (genvar j = 0; j < NS; j++) begin : g_stage
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_amt;
    logic          in_dir;
    logic          in_v;
    logic [N-1:0]  nxt;

    if (j == 0) begin : g_first
      assign in_data = up_data;
      assign in_amt  = up_amt;
      assign in_dir  = up_dir;
      assign in_v    = up_valid;
    end else begin : g_chain
      assign in_data = data_q[j-1];
      assign in_amt  = amt_q[j-1];
      assign in_dir  = dir_q[j-1];
      assign in_v    = v_q[j-1];
    end

    if (InReg != 0 && j == 0) begin : g_inreg
      assign nxt = in_data;
    end else begin : g_rot
      localparam int unsigned K = j - InReg;
      assign nxt = in_amt[K] ? rot_pow2(in_data, in_dir, 2 ** K) : in_data;
    end

    // A stage may load when empty or when the stage after it is moving.
    assign en[j]     = !v_q[j] || en[j+1];
    assign data_d[j] = en[j] ? nxt    : data_q[j];
    assign amt_d[j]  = en[j] ? in_amt : amt_q[j];
    assign dir_d[j]  = en[j] ? in_dir : dir_q[j];
    assign v_d[j]    = en[j] ? in_v   : v_q[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      dir_q  <= '0;
      data_q <= '0;
      amt_q  <= '0;
    end else begin
      v_q    <= v_d;
      dir_q  <= dir_d;
      data_q <= data_d;
      amt_q  <= amt_d;
    end
  end

  assign up_ready   = en[0];
  assign down_valid = v_q[NS-1];
  assign down_data  = data_q[NS-1];

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Directed and random bench for pipelined_barrel_rotator with a reference-model scoreboard.
module tb_pipelined_barrel_rotator;
  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;
  localparam int          NI = 8;
`ifdef BARREL_ROTATOR_IN_REG_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [N-1:0]  up_data = '0;
  logic [SW-1:0] up_amt = '0;
  logic          up_dir = 1'b0;
  logic          down_valid;
  logic          down_ready = 1'b0;
  logic [N-1:0]  down_data;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;
  int n_out = 0;
  bit up_fire = 1'b0;
  logic [N-1:0] sb[$];
  int out_cyc[$];

  pipelined_barrel_rotator #(.N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .up_amt    (up_amt),
    .up_dir    (up_dir),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data (down_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [N-1:0] ref_rot(input logic [N-1:0] x, input logic [SW-1:0] s,
                                           input logic dir);
    logic [N-1:0] r;
    int sh;
    r  = '0;
    sh = int'(s);
    for (int i = 0; i < NI; i++) begin
      if (!dir) r[(i + sh) % NI] = x[i];
      else      r[i] = x[(i + sh) % NI];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on upstream transfer, pop and compare on downstream transfer.
  always @(negedge clk) begin
    logic [N-1:0] exp;
    up_fire = 1'b0;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (up_valid && up_ready) begin
        sb.push_back(ref_rot(up_data, up_amt, up_dir));
        up_fire = 1'b1;
      end
      if (down_valid && down_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          chk("down_data", 32'(down_data), 32'(exp));
        end
        n_out++;
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d, input logic [SW-1:0] a, input logic dr);
    up_valid = 1'b1;
    up_data  = d;
    up_amt   = a;
    up_dir   = dr;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (up_fire) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cycles;
    int acc;
    int n0;
    int idx0;
    logic [N-1:0] w_data[5];
    logic [SW-1:0] w_amt[5];
    logic w_dir[5];

    // Reset state
    tick();
    tick();
    chk("rst_down_valid", 32'(down_valid), 0);
    chk("rst_down_data", 32'(down_data), 0);
    chk("rst_up_ready", 32'(up_ready), 1);
    rst_n = 1'b1;
    tick();

    // 1: single word latency and value
    down_ready = 1'b1;
    up_valid = 1'b1;
    up_data = 8'b10110101;
    up_amt = 3'd3;
    up_dir = 1'b0;
    tick();
    up_valid = 1'b0;
    cycles = 1;
    while (!down_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("latency", 32'(cycles), 32'(LAT));
    chk("t1_data", 32'(down_data), 32'(8'b10101101));
    repeat (2) tick();

    // 2: right rotation and both directions of a second pattern
    send(8'b10110101, 3'd3, 1'b1);
    send(8'b01100110, 3'd3, 1'b1);
    send(8'b01100110, 3'd3, 1'b0);
    up_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("t2_drained", 32'(sb.size()), 0);

    // 3: back-to-back stream at full throughput
    n0 = n_out;
    idx0 = out_cyc.size();
    cycles = cyc;
    for (int i = 0; i < 8; i++) send(8'b00000001, SW'(i), 1'b0);
    chk("stream_accept_cycles", 32'(cyc - cycles), 8);
    up_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("stream_out_count", 32'(n_out - n0), 8);
    if (out_cyc.size() >= idx0 + 8)
      chk("stream_consecutive", 32'(out_cyc[idx0+7] - out_cyc[idx0]), 7);
    else
      chk("stream_out_present", 32'(out_cyc.size() - idx0), 8);

    // 4: backpressure fills the pipeline, then release
    for (int i = 0; i < 5; i++) begin
      w_data[i] = N'(8'h5A + 8'(i * 37));
      w_amt[i]  = SW'(i + 1);
      w_dir[i]  = i[0];
    end
    down_ready = 1'b0;
    n0 = n_out;
    acc = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      if (acc < 5) begin
        up_valid = 1'b1;
        up_data  = w_data[acc];
        up_amt   = w_amt[acc];
        up_dir   = w_dir[acc];
      end
      #2;
      chk("bp_up_ready", 32'(up_ready), 32'(acc < LAT));
      if (acc >= LAT) begin
        chk("bp_hold_valid", 32'(down_valid), 1);
        chk("bp_hold_data", 32'(down_data), 32'(ref_rot(w_data[0], w_amt[0], w_dir[0])));
      end
      tick();
      if (up_fire) acc++;
    end
    down_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      up_valid = 1'b1;
      up_data  = w_data[acc];
      up_amt   = w_amt[acc];
      up_dir   = w_dir[acc];
      tick();
      if (up_fire) acc++;
    end
    up_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("bp_accepted", 32'(acc), 5);
    chk("bp_out_count", 32'(n_out - n0), 5);
    chk("bp_drained", 32'(sb.size()), 0);

    // 5: asynchronous reset with words in flight
    down_ready = 1'b0;
    send(8'h11, 3'd1, 1'b0);
    send(8'h22, 3'd2, 1'b1);
    up_valid = 1'b0;
    repeat (LAT) tick();
    chk("pre_reset_valid", 32'(down_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(down_valid), 0);
    chk("async_rst_data", 32'(down_data), 0);
    chk("async_rst_up_ready", 32'(up_ready), 1);
    tick();
    rst_n = 1'b1;
    down_ready = 1'b1;
    n0 = n_out;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("no_stale_valid", 32'(down_valid), 0);
    end
    chk("no_stale_out", 32'(n_out - n0), 0);

    // 6: random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      down_ready = ($urandom_range(0, 3) != 0);
      if (!(up_valid && !up_fire)) begin
        up_valid = ($urandom_range(0, 3) != 0);
        up_data  = N'($urandom);
        up_amt   = SW'($urandom_range(0, NI - 1));
        up_dir   = 1'($urandom_range(0, 1));
      end
      tick();
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    repeat (LAT + 4) tick();
    chk("rand_drained", 32'(sb.size()), 0);
    chk("rand_idle_valid", 32'(down_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
